// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller and mul/div sequencer for the 5-stage pipeline
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 33,
  parameter int CNT_W     = 6
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       isMul_dx,
  input  logic       isDiv_dx,
  input  logic       isLw_dx,
  input  logic [4:0] rd_dx,
  input  logic [4:0] rs_fd,
  input  logic [4:0] rt_fd,
  input  logic       uses_rs_fd,
  input  logic       uses_rt_fd,
  input  logic       branch_taken_x,
  input  logic       md_ready,
  output logic       md_start,
  output logic       md_busy,
  output logic       ena_pc,
  output logic       ena_fd,
  output logic       ena_dx,
  output logic       flush_fd,
  output logic       flush_dx,
  output logic       bubble_xm,
  output logic       md_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             md_req;
  logic             load_use;
  logic             run_limit;

  assign md_req    = isMul_dx | isDiv_dx;
  assign run_limit = (cnt == CNT_LAST);
  // $0 is hardwired zero, so a lw targeting it never creates a dependency
  assign load_use  = isLw_dx & (rd_dx != 5'd0) &
                     ((uses_rs_fd & (rs_fd == rd_dx)) | (uses_rt_fd & (rt_fd == rd_dx)));

  // state register, RUN counter, registered start pulse and sticky timeout flag
  always_ff @(posedge clock) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= '0;
      md_start   <= 1'b0;
      md_timeout <= 1'b0;
    end else begin
      state    <= next_state;
      md_start <= (state == IDLE) && !branch_taken_x && md_req;
      if (state == IDLE) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
      end
      // md_ready wins over the limit, so a result on the last cycle is not a timeout
      if ((state == RUN) && !md_ready && run_limit) begin
        md_timeout <= 1'b1;
      end
    end
  end

  // next-state logic; a taken branch in X suppresses the mul/div start
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (!branch_taken_x && md_req) next_state = RUN;
      RUN:  if (md_ready || run_limit) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // pipeline register controls; hazard decisions are held off while clr is asserted
  always_comb begin
    md_busy   = 1'b0;
    ena_pc    = 1'b1;
    ena_fd    = 1'b1;
    ena_dx    = 1'b1;
    flush_fd  = 1'b0;
    flush_dx  = 1'b0;
    bubble_xm = 1'b0;
    case (state)
      IDLE: begin
        if (!clr) begin
          if (branch_taken_x) begin
            flush_fd = 1'b1;
            flush_dx = 1'b1;
          end else if (md_req) begin
            ena_pc    = 1'b0;
            ena_fd    = 1'b0;
            ena_dx    = 1'b0;
            bubble_xm = 1'b1;
          end else if (load_use) begin
            ena_pc   = 1'b0;
            ena_fd   = 1'b0;
            flush_dx = 1'b1;
          end
        end
      end
      RUN: begin
        md_busy   = 1'b1;
        ena_pc    = 1'b0;
        ena_fd    = 1'b0;
        ena_dx    = 1'b0;
        bubble_xm = 1'b1;
      end
      DONE: begin
        // all enables stay high so X/M captures the result and D/X advances
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the enable and clear inputs of the F/D, D/X and X/M pipeline registers and the PC register. It detects load-use hazards and resolves taken branches and jumps. It also sequences the multicycle mul/div unit in X: a start pulse, a stall while busy, a cycle timeout, and release on completion.

Parameters:
MD_CYCLES, 33, maximum RUN cycles allowed for a mul/div before forced completion
CNT_W, 6, width of the RUN cycle counter; requires 2^CNT_W > MD_CYCLES

Ports:
clock  in  1  system clock, all state updates on rising edge
clr  in  1  synchronous active-high reset
isMul_dx  in  1  instruction currently in X is mul
isDiv_dx  in  1  instruction currently in X is div
isLw_dx  in  1  instruction currently in X is lw
rd_dx  in  5  destination register of the instruction in X
rs_fd  in  5  rs field of the instruction in D
rt_fd  in  5  rt field of the instruction in D
uses_rs_fd  in  1  instruction in D reads rs
uses_rt_fd  in  1  instruction in D reads rt
branch_taken_x  in  1  taken bne/blt/j/jal/jr/bex resolved in X
md_ready  in  1  mul/div unit result valid
md_start  out  1  one-cycle start pulse to the mul/div unit
md_busy  out  1  high while state is RUN
ena_pc  out  1  PC register enable
ena_fd  out  1  F/D register enable
ena_dx  out  1  D/X register enable
flush_fd  out  1  synchronous clear of F/D (inserts nop)
flush_dx  out  1  synchronous clear of D/X (inserts nop)
bubble_xm  out  1  X/M captures a nop instead of the X result
md_timeout  out  1  sticky flag, set when a mul/div hit MD_CYCLES without md_ready

Behaviour:
- FSM states: IDLE, RUN, DONE. Counter cnt is CNT_W bits wide.
- Reset (clr=1 at an edge): state=IDLE, cnt=0, md_start=0, md_timeout=0. This applies in any state, including mid-RUN; an in-flight mul/div is abandoned.
- Defaults, combinational: ena_pc=ena_fd=ena_dx=1, all flush signals and bubble_xm 0.

IDLE:
- If branch_taken_x: flush_fd=1, flush_dx=1, and stay in IDLE. Branch has priority over all other conditions, even if isMul_dx/isDiv_dx are erroneously high.
- Else if (isMul_dx|isDiv_dx):
  - next state RUN, cnt<=0, md_start<=1 (registered, so the pulse is high in the first RUN cycle only).
  - In this cycle: ena_pc=ena_fd=ena_dx=0, bubble_xm=1.
- Else if load-use hazard: ena_pc=0, ena_fd=0, flush_dx=1. A load-use hazard is isLw_dx & (rd_dx!=0) & ((uses_rs_fd & rs_fd==rd_dx) | (uses_rt_fd & rt_fd==rd_dx)).
  - Exactly one bubble is inserted; on the next cycle the lw is in M and the hazard clears.
- Register $0 never causes a stall.

RUN:
- Outputs: md_busy=1, ena_pc=ena_fd=ena_dx=0, bubble_xm=1. md_start is 1 only in the first RUN cycle, 0 afterwards.
- cnt increments by 1 each cycle.
- If md_ready=1: next state DONE. This is permitted even in the first RUN cycle.
- Else if cnt==MD_CYCLES-1: next state DONE, md_timeout<=1.
- If md_ready and the timeout condition occur in the same cycle, md_ready wins and md_timeout is not set.
- branch_taken_x is ignored in RUN because X holds the mul/div.

DONE (exactly one cycle):
- All enables are 1 and bubble_xm=0, so X/M captures the result and D/X advances. Next state IDLE.
- Load-use and md-start detection are not evaluated in DONE.
- A back-to-back mul/div is detected in the following IDLE cycle.

General:
- md_timeout stays set until clr.
- Latency from mul/div entering X to its result in X/M: R+2 edges, where R is the number of RUN cycles (1 detect cycle, R RUN cycles, 1 DONE cycle).

Test Plan:
- Reset: hold clr for 2 cycles while isMul_dx=1 -> all enables 1, md_start=0, md_busy=0, md_timeout=0. Release -> RUN next cycle with md_start=1 for exactly one cycle.
- Mul: isMul_dx=1 in IDLE, md_ready rises on the 5th RUN cycle -> md_busy high 5 cycles, enables 0 and bubble_xm=1 for 6 cycles, then DONE with ena_dx=1 and bubble_xm=0, then IDLE.
- Timeout: isDiv_dx=1, md_ready held 0 -> DONE after exactly 33 RUN cycles, md_timeout=1 and still 1 after a later normal mul. md_ready=1 on the 33rd RUN cycle instead -> md_timeout stays 0.
- Load-use: isLw_dx=1, rd_dx=5, rt_fd=5, uses_rt_fd=1 -> one cycle of ena_pc=0, ena_fd=0, flush_dx=1. Repeat with rd_dx=0, or with uses_rt_fd=0 -> no stall.
- Branch priority: branch_taken_x=1 together with a load-use hazard -> flush_fd=1, flush_dx=1, ena_pc=1, state remains IDLE.
- Reset mid-RUN: clr on the 3rd RUN cycle -> next cycle IDLE with cnt=0 and md_busy=0. A new mul then starts cleanly with a fresh md_start pulse.
